// File: rtl/elpis_in_pkg.sv
// elpis_in_pkg: shared defaults, core word width and handshake FSM encoding for the Elpis input port
package elpis_in_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CORE_W = 32;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
endpackage

// File: rtl/elpis_in_if.sv
// elpis_in_if: external 4-phase source side plus core IN-instruction side of the Elpis input port
interface elpis_in_if
  import elpis_in_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  logic [DATA_W-1:0] io_data_i;
  logic io_strobe_i;
  logic io_ack_o;
  logic core_in_req_i;
  logic core_in_valid_o;
  logic [CORE_W-1:0] core_in_data_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
  logic overflow_o;
  modport master (
    output io_data_i, io_strobe_i, core_in_req_i,
    input io_ack_o, core_in_valid_o, core_in_data_o, fifo_count_o, overflow_o
  );
  modport slave (
    input io_data_i, io_strobe_i, core_in_req_i,
    output io_ack_o, core_in_valid_o, core_in_data_o, fifo_count_o, overflow_o
  );
endinterface

// File: rtl/elpis_sync2.sv
// elpis_sync2: two-flop synchronizer with asynchronous active-high reset to 0
module elpis_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/elpis_in_port.sv
// elpis_in_port: 4-phase asynchronous input capture into a show-ahead FIFO popped by the core.
// Define ELPIS_IN_SIGN_EXT_EN to sign-extend entries to 32 bits (default zero-extends).
module elpis_in_port
  import elpis_in_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  elpis_in_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic strobe_s, edge_q, armed, rise, push, pop, full, wr_en, overflow;
  logic [1:0] warm;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DATA_W-1:0] head;
  elpis_sync2 u_sync (.clk(wb_clk_i), .rst(wb_rst_i), .d(bus.io_strobe_i), .q(strobe_s));
  // the synchronizer reads 0 straight out of reset, so arming waits until it holds a real strobe sample
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      edge_q <= 1'b0;
      warm <= 2'b00;
      armed <= 1'b0;
    end else begin
      edge_q <= strobe_s;
      warm <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~strobe_s);
    end
  assign rise = armed & strobe_s & ~edge_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    push = (state == IDLE) && rise;
    state_n = push ? ACK : ((state == ACK) && !strobe_s) ? IDLE : state;
  end
  assign full = count == (AW+1)'(DEPTH);
  assign pop = bus.core_in_req_i && count != '0;
  assign wr_en = push && (!full || pop);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr] <= bus.io_data_i;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow <= overflow | (push & full & ~pop);
    end
  assign head = mem[rd_ptr];
  assign bus.io_ack_o = state == ACK;
  assign bus.core_in_valid_o = count != '0;
  assign bus.fifo_count_o = count;
  assign bus.overflow_o = overflow;
`ifdef ELPIS_IN_SIGN_EXT_EN
  assign bus.core_in_data_o = CORE_W'(signed'(head));
`else
  assign bus.core_in_data_o = CORE_W'(head);
`endif
endmodule

// File: tb/tb_elpis_in_port.sv
// tb_elpis_in_port: randomized scoreboard bench for elpis_in_port against a queue model of the FIFO
module tb_elpis_in_port;
  localparam int DATA_W = 16;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int failures = 0;
  logic [15:0] model[$];
  logic [15:0] cur_word = '0;
  bit exp_ovf = 0;
  bit pushed = 0;
  bit rand_done = 0;
  elpis_in_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  elpis_in_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] ext(input logic [15:0] w);
`ifdef ELPIS_IN_SIGN_EXT_EN
    return {{16{w[15]}}, w};
`else
    return {16'h0000, w};
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // monitor: pops expected words when the core pops, pushes on each capture
  initial forever begin
    logic p_req, p_valid, p_ack;
    logic [31:0] p_data;
    logic [15:0] e;
    @(posedge clk);
    if (rst) continue;
    p_req = bus.core_in_req_i;
    p_valid = bus.core_in_valid_o;
    p_ack = bus.io_ack_o;
    p_data = bus.core_in_data_o;
    #1;
    if (rst) continue;
    chk("valid", 32'(p_valid), 32'(model.size() != 0));
    if (p_req && model.size() != 0) begin
      e = model.pop_front();
      chk("pop_data", p_data, ext(e));
    end
    if (bus.io_ack_o && !p_ack) begin
      pushed = 1;
      if (model.size() < DEPTH) model.push_back(cur_word);
      else exp_ovf = 1;
    end
    chk("count", 32'(bus.fifo_count_o), 32'(model.size()));
    chk("overflow", 32'(bus.overflow_o), 32'(exp_ovf));
    if (model.size() != 0) chk("head", bus.core_in_data_o, ext(model[0]));
    else if (!pushed) chk("head_clear", bus.core_in_data_o, 32'h0);
  end
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1;
    #1;
    model.delete();
    exp_ovf = 0;
    pushed = 0;
    chk("rst_ack", 32'(bus.io_ack_o), 0);
    chk("rst_valid", 32'(bus.core_in_valid_o), 0);
    chk("rst_count", 32'(bus.fifo_count_o), 0);
    chk("rst_ovf", 32'(bus.overflow_o), 0);
    chk("rst_data", bus.core_in_data_o, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (bus.io_ack_o !== lvl && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    if (bus.io_ack_o !== lvl) chk("ack_timeout", 32'(bus.io_ack_o), 32'(lvl));
  endtask
  task automatic send_word(input logic [15:0] w, input bit pop_at_cap);
    int n = 0;
    @(negedge clk);
    bus.io_data_i = w;
    cur_word = w;
    bus.io_strobe_i = 1;
    while (!bus.io_ack_o && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (pop_at_cap && n == 2 && !bus.io_ack_o) begin
        @(negedge clk);
        bus.core_in_req_i = 1;
      end
      if (pop_at_cap && n == 3) begin
        @(negedge clk);
        bus.core_in_req_i = 0;
      end
    end
    chk("ack_latency", 32'(n), 3);
    @(negedge clk);
    bus.io_strobe_i = 0;
    wait_ack(1'b0);
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    bus.core_in_req_i = 1;
    while (bus.core_in_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.core_in_req_i = 0;
    chk("drain_empty", 32'(bus.core_in_valid_o), 0);
  endtask
  initial begin
    bus.io_data_i = '0;
    bus.io_strobe_i = 0;
    bus.core_in_req_i = 0;
    do_reset();
    send_word(16'h1234, 0);
    chk("first_data", bus.core_in_data_o, 32'h0000_1234);
    chk("first_count", 32'(bus.fifo_count_o), 1);
    drain();
    do_reset();
    for (int i = 1; i <= 5; i++) send_word(16'(i), 0);
    chk("full_count", 32'(bus.fifo_count_o), 4);
    chk("full_ovf", 32'(bus.overflow_o), 1);
    drain();
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(16'(i), 0);
    send_word(16'h0005, 1);
    chk("pp_count", 32'(bus.fifo_count_o), 4);
    chk("pp_ovf", 32'(bus.overflow_o), 0);
    chk("pp_head", bus.core_in_data_o, 32'h0000_0002);
    drain();
    do_reset();
    send_word(16'h8001, 0);
`ifdef ELPIS_IN_SIGN_EXT_EN
    chk("sign_ext", bus.core_in_data_o, 32'hFFFF_8001);
`else
    chk("zero_ext", bus.core_in_data_o, 32'h0000_8001);
`endif
    drain();
    do_reset();
    @(negedge clk);
    bus.io_data_i = 16'hBEEF;
    cur_word = 16'hBEEF;
    bus.io_strobe_i = 1;
    wait_ack(1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_recapture", 32'(bus.io_ack_o), 0);
    end
    bus.io_strobe_i = 0;
    repeat (4) @(negedge clk);
    send_word(16'h0042, 0);
    chk("recapture_count", 32'(bus.fifo_count_o), 1);
    drain();
    do_reset();
    @(negedge clk);
    bus.core_in_req_i = 1;
    repeat (10) @(negedge clk);
    send_word(16'h0077, 0);
    chk("req_empty_count", 32'(bus.fifo_count_o), 0);
    bus.core_in_req_i = 0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send_word(16'($urandom()), 0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus.core_in_req_i = ($urandom_range(0, 9) < 3);
        end
        bus.core_in_req_i = 0;
      end
    join
    drain();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
